// File: rtl/reg_arb_pkg.sv
// Shared constants and FSM encoding for the register-bank access arbiter.
// Optional range checking is selected by REG_ARB_RANGE_CHECK_EN in the top.
package reg_arb_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } state_e;

endpackage

// File: rtl/reg_access_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant from the request pair and the
// pointer, plus the pointer value to use once a grant is taken.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       advance_i,
    output logic [1:0] gnt_c_o,
    output logic       ptr_nxt_c_o
);

    always_comb begin
        gnt_c_o     = 2'b00;
        ptr_nxt_c_o = ptr_i;
        case (req_i)
            2'b01:   gnt_c_o = 2'b01;
            2'b10:   gnt_c_o = 2'b10;
            2'b11:   gnt_c_o = (ptr_i == PORT_B) ? 2'b10 : 2'b01;
            default: gnt_c_o = 2'b00;
        endcase
        // The port just served goes to the back of the line.
        if (advance_i && gnt_c_o[PORT_A]) begin
            ptr_nxt_c_o = PORT_B;
        end
        if (advance_i && gnt_c_o[PORT_B]) begin
            ptr_nxt_c_o = PORT_A;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates I2C (port A) and host (port B) accesses onto a single-port register bank.
// Define REG_ARB_RANGE_CHECK_EN to block and flag accesses at or above NUM_REGS.
module reg_access_arbiter #(
    parameter int unsigned ADDR_W   = reg_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = reg_arb_pkg::DATA_W,
    parameter int unsigned NUM_REGS = reg_arb_pkg::NUM_REGS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_err_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_err_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_din_o,
    output logic              reg_we_o,
    input  logic [DATA_W-1:0] reg_dout_i,
    output logic              busy_o
);
    import reg_arb_pkg::*;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_din_q, reg_din_d;
    logic              reg_we_q, reg_we_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic              a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              busy_q, busy_d;

    logic [1:0]        elig_c, gnt_c;
    logic              ptr_nxt_c, grant_b_c, sel_we_c, sel_oor_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // A port is not eligible in the cycle its ack is high, so a held req is a new request.
    assign elig_c = {b_req_i & ~b_ack_q, a_req_i & ~a_ack_q};

    rr_arb2 u_rr_arb2 (
        .req_i       (elig_c),
        .ptr_i       (ptr_q),
        .advance_i   (state_q == IDLE),
        .gnt_c_o     (gnt_c),
        .ptr_nxt_c_o (ptr_nxt_c)
    );

    assign grant_b_c   = gnt_c[PORT_B];
    assign sel_we_c    = grant_b_c ? b_we_i    : a_we_i;
    assign sel_addr_c  = grant_b_c ? b_addr_i  : a_addr_i;
    assign sel_wdata_c = grant_b_c ? b_wdata_i : a_wdata_i;

`ifdef REG_ARB_RANGE_CHECK_EN
    assign sel_oor_c = (32'(sel_addr_c) >= NUM_REGS);
`else
    assign sel_oor_c = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        oor_d      = oor_q;
        reg_addr_d = reg_addr_q;
        reg_din_d  = reg_din_q;
        reg_we_d   = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_err_d    = a_err_q;
        b_err_d    = b_err_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_c != 2'b00) begin
                    state_d    = ISSUE;
                    ptr_d      = ptr_nxt_c;
                    owner_d    = grant_b_c ? PORT_B : PORT_A;
                    we_d       = sel_we_c;
                    oor_d      = sel_oor_c;
                    reg_addr_d = sel_addr_c;
                    reg_din_d  = sel_wdata_c;
                    reg_we_d   = sel_we_c & ~sel_oor_c;
                end
            end
            ISSUE: begin
                state_d = CAPT;
            end
            CAPT: begin
                // Bank output now reflects the issued address.
                state_d = IDLE;
                if (owner_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    a_err_d = oor_q;
                    if (!we_q) begin
                        a_rdata_d = oor_q ? '0 : reg_dout_i;
                    end
                end else begin
                    b_ack_d = 1'b1;
                    b_err_d = oor_q;
                    if (!we_q) begin
                        b_rdata_d = oor_q ? '0 : reg_dout_i;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= PORT_A;
            owner_q    <= PORT_A;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            reg_addr_q <= '0;
            reg_din_q  <= '0;
            reg_we_q   <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            oor_q      <= oor_d;
            reg_addr_q <= reg_addr_d;
            reg_din_q  <= reg_din_d;
            reg_we_q   <= reg_we_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign a_ack_o    = a_ack_q;
    assign a_err_o    = a_err_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_ack_o    = b_ack_q;
    assign b_err_o    = b_err_q;
    assign b_rdata_o  = b_rdata_q;
    assign reg_addr_o = reg_addr_q;
    assign reg_din_o  = reg_din_q;
    assign busy_o     = busy_q;
    // A reset landing on the issue cycle must also cancel the bank write.
    assign reg_we_o   = reg_we_q & ~rst_i;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed scenarios plus randomized two-port traffic
// checked against a serialized register-file model; honours REG_ARB_RANGE_CHECK_EN.
module tb_reg_access_arbiter;

    localparam int unsigned NREGS = 16;
`ifdef REG_ARB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, a_ack, a_err;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_req, b_we, b_ack, b_err;
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic [7:0] reg_addr, reg_din, reg_dout;
    logic       reg_we, busy;

    logic [7:0] bank_mem [256] = '{default: 8'h00};
    logic [7:0] shadow   [256];

    int   checks = 0;
    int   fails  = 0;
    bit   done_a, done_b;
    int   we_seen, we_expected;
    txn_t qa[$];
    txn_t qb[$];
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    reg_access_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .a_req_i    (a_req),
        .a_we_i     (a_we),
        .a_addr_i   (a_addr),
        .a_wdata_i  (a_wdata),
        .a_ack_o    (a_ack),
        .a_rdata_o  (a_rdata),
        .a_err_o    (a_err),
        .b_req_i    (b_req),
        .b_we_i     (b_we),
        .b_addr_i   (b_addr),
        .b_wdata_i  (b_wdata),
        .b_ack_o    (b_ack),
        .b_rdata_o  (b_rdata),
        .b_err_o    (b_err),
        .reg_addr_o (reg_addr),
        .reg_din_o  (reg_din),
        .reg_we_o   (reg_we),
        .reg_dout_i (reg_dout),
        .busy_o     (busy)
    );

    // Register bank with registered read port
    always @(posedge clk) begin
        if (reg_we) bank_mem[reg_addr] <= reg_din;
        reg_dout <= bank_mem[reg_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v);
        if (p) b_req = v;
        else   a_req = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic do_access(input bit p, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, output bit ok);
        int w = 0;
        if (p) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
        else   begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
        ok = 1'b0;
        while (!ok && w < 12) begin
            tick();
            w++;
            ok = p ? (b_ack === 1'b1) : (a_ack === 1'b1);
        end
        set_req(p, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, a_ack, b_ack, a_err, b_err, reg_we} !== 6'b0) begin
            $display("FAIL reset_flags: got %b expected 000000", {busy, a_ack, b_ack, a_err, b_err, reg_we});
            fails++;
        end
        checks++;
        if ({a_rdata, b_rdata} !== 16'h0000) begin
            $display("FAIL reset_rdata: got %h expected 0000", {a_rdata, b_rdata});
            fails++;
        end
        checks++;
        if ({reg_addr, reg_din} !== 16'h0000) begin
            $display("FAIL reset_bank_bus: got %h expected 0000", {reg_addr, reg_din});
            fails++;
        end
    endtask

    task automatic test_write_read();
        do_reset();
        a_we = 1'b1; a_addr = 8'h03; a_wdata = 8'hA5; a_req = 1'b1;
        tick();
        checks++;
        if ({busy, reg_we, reg_addr, reg_din} !== {1'b1, 1'b1, 8'h03, 8'hA5}) begin
            $display("FAIL wr_issue: got busy=%b we=%b addr=%h din=%h expected 1 1 03 a5", busy, reg_we, reg_addr, reg_din);
            fails++;
        end
        tick();
        checks++;
        if ({a_ack, reg_we, reg_addr} !== {1'b0, 1'b0, 8'h03}) begin
            $display("FAIL wr_capt: got ack=%b we=%b addr=%h expected 0 0 03", a_ack, reg_we, reg_addr);
            fails++;
        end
        tick();
        checks++;
        if ({a_ack, a_err, b_ack} !== 3'b100) begin
            $display("FAIL wr_ack: got a_ack=%b a_err=%b b_ack=%b expected 1 0 0", a_ack, a_err, b_ack);
            fails++;
        end
        a_req = 1'b0;
        tick();
        checks++;
        if ({a_ack, busy} !== 2'b00) begin
            $display("FAIL wr_ack_pulse: got ack=%b busy=%b expected 0 0", a_ack, busy);
            fails++;
        end
        a_we = 1'b0; a_addr = 8'h03; a_wdata = 8'h00; a_req = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_ack, a_err, a_rdata} !== {1'b1, 1'b0, 8'hA5}) begin
            $display("FAIL rd_back: got ack=%b err=%b rdata=%h expected 1 0 a5", a_ack, a_err, a_rdata);
            fails++;
        end
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        a_we = 1'b1; a_addr = 8'h04; a_wdata = 8'h22;
        b_we = 1'b1; b_addr = 8'h05; b_wdata = 8'h11;
        a_req = 1'b1; b_req = 1'b1;
        tick();
        checks++;
        if ({reg_we, reg_addr, reg_din} !== {1'b1, 8'h04, 8'h22}) begin
            $display("FAIL sim_first_grant: got we=%b addr=%h din=%h expected 1 04 22", reg_we, reg_addr, reg_din);
            fails++;
        end
        repeat (2) tick();
        checks++;
        if ({a_ack, b_ack} !== 2'b10) begin
            $display("FAIL sim_a_ack: got a_ack=%b b_ack=%b expected 1 0", a_ack, b_ack);
            fails++;
        end
        a_req = 1'b0;
        tick();
        checks++;
        if ({reg_we, reg_addr, reg_din, a_ack} !== {1'b1, 8'h05, 8'h11, 1'b0}) begin
            $display("FAIL sim_second_grant: got we=%b addr=%h din=%h a_ack=%b expected 1 05 11 0", reg_we, reg_addr, reg_din, a_ack);
            fails++;
        end
        repeat (2) tick();
        checks++;
        if ({a_ack, b_ack} !== 2'b01) begin
            $display("FAIL sim_b_ack: got a_ack=%b b_ack=%b expected 0 1", a_ack, b_ack);
            fails++;
        end
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0, na = 0, nb = 0, cyc = 0, extra = 0;
        bit exp_b;
        do_reset();
        a_we = 1'b1; a_addr = 8'h01; a_wdata = 8'h10;
        b_we = 1'b1; b_addr = 8'h02; b_wdata = 8'h20;
        a_req = 1'b1; b_req = 1'b1;
        while (n < 6 && cyc < 40) begin
            tick();
            cyc++;
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                exp_b = (n % 2) == 1;
                checks++;
                if (a_ack === b_ack || b_ack !== exp_b || cyc != 3 * (n + 1)) begin
                    $display("FAIL b2b_order: idx=%0d got a_ack=%b b_ack=%b cycle=%0d expected b_ack=%b cycle=%0d",
                             n, a_ack, b_ack, cyc, exp_b, 3 * (n + 1));
                    fails++;
                end
                n++;
                if (a_ack === 1'b1) begin
                    na++;
                    if (na == 3) a_req = 1'b0;
                    else a_wdata = 8'h10 + 8'(na);
                end
                if (b_ack === 1'b1) begin
                    nb++;
                    if (nb == 3) b_req = 1'b0;
                    else b_wdata = 8'h20 + 8'(nb);
                end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checks++;
        if (n != 6) begin
            $display("FAIL b2b_count: got %0d acks expected 6", n);
            fails++;
        end
        repeat (6) begin
            tick();
            if (a_ack !== 1'b0 || b_ack !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL b2b_extra_ack: got %0d extra acks expected 0", extra);
            fails++;
        end
        checks++;
        if ({bank_mem[1], bank_mem[2]} !== 16'h1222) begin
            $display("FAIL b2b_bank: got %h expected 1222", {bank_mem[1], bank_mem[2]});
            fails++;
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int bad = 0;
        do_reset();
        do_access(1'b0, 1'b1, 8'h07, 8'h5A, ok);
        checks++;
        if (!ok) begin
            $display("FAIL abort_setup: got no a_ack expected a_ack");
            fails++;
        end
        b_we = 1'b1; b_addr = 8'h07; b_wdata = 8'h3C; b_req = 1'b1;
        tick();
        checks++;
        if ({reg_we, reg_addr, reg_din} !== {1'b1, 8'h07, 8'h3C}) begin
            $display("FAIL abort_issue: got we=%b addr=%h din=%h expected 1 07 3c", reg_we, reg_addr, reg_din);
            fails++;
        end
        rst = 1'b1;
        b_req = 1'b0;
        #1;
        checks++;
        if (reg_we !== 1'b0) begin
            $display("FAIL abort_we_gated: got %b expected 0", reg_we);
            fails++;
        end
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, b_ack} !== 2'b00) begin
            $display("FAIL abort_idle: got busy=%b b_ack=%b expected 0 0", busy, b_ack);
            fails++;
        end
        repeat (4) begin
            tick();
            if (b_ack !== 1'b0 || reg_we !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
            fails++;
        end
        checks++;
        if (bank_mem[7] !== 8'h5A) begin
            $display("FAIL abort_reg: got %h expected 5a", bank_mem[7]);
            fails++;
        end
    endtask

    task automatic test_range();
        bit ok;
        logic       exp_we, exp_err;
        logic [7:0] exp_rdv;
`ifdef REG_ARB_RANGE_CHECK_EN
        exp_we = 1'b0; exp_err = 1'b1; exp_rdv = 8'h00;
`else
        exp_we = 1'b1; exp_err = 1'b0; exp_rdv = 8'hFF;
`endif
        do_reset();
        do_access(1'b0, 1'b0, 8'h03, 8'h00, ok);
        checks++;
        if (!ok || a_rdata !== 8'hA5 || a_err !== 1'b0) begin
            $display("FAIL range_pre_read: got ok=%b rdata=%h err=%b expected 1 a5 0", ok, a_rdata, a_err);
            fails++;
        end
        tick();
        a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'hFF; a_req = 1'b1;
        tick();
        checks++;
        if ({reg_we, reg_addr} !== {exp_we, 8'h20}) begin
            $display("FAIL range_wr_issue: got we=%b addr=%h expected %b 20", reg_we, reg_addr, exp_we);
            fails++;
        end
        repeat (2) tick();
        checks++;
        if ({a_ack, a_err} !== {1'b1, exp_err}) begin
            $display("FAIL range_wr_ack: got ack=%b err=%b expected 1 %b", a_ack, a_err, exp_err);
            fails++;
        end
        a_req = 1'b0;
        tick();
        a_we = 1'b0; a_addr = 8'h20; a_req = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a_ack, a_err, a_rdata} !== {1'b1, exp_err, exp_rdv}) begin
            $display("FAIL range_rd: got ack=%b err=%b rdata=%h expected 1 %b %h", a_ack, a_err, a_rdata, exp_err, exp_rdv);
            fails++;
        end
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_drop_req();
        bit ok1, ok2;
        do_reset();
        do_access(1'b0, 1'b1, 8'h09, 8'h66, ok1);
        tick();
        do_access(1'b1, 1'b0, 8'h03, 8'h00, ok2);
        checks++;
        if (!ok1 || !ok2 || b_rdata !== 8'hA5) begin
            $display("FAIL drop_setup: got ok=%b%b b_rdata=%h expected 11 a5", ok1, ok2, b_rdata);
            fails++;
        end
        tick();
        a_we = 1'b0; a_addr = 8'h09; a_req = 1'b1;
        tick();
        a_req = 1'b0; a_we = 1'b1; a_addr = 8'h0F; a_wdata = 8'hEE;
        checks++;
        if ({reg_we, reg_addr} !== {1'b0, 8'h09}) begin
            $display("FAIL drop_issue: got we=%b addr=%h expected 0 09", reg_we, reg_addr);
            fails++;
        end
        repeat (2) tick();
        checks++;
        if ({a_ack, a_rdata, b_ack, b_rdata} !== {1'b1, 8'h66, 1'b0, 8'hA5}) begin
            $display("FAIL drop_ack: got a_ack=%b a_rdata=%h b_ack=%b b_rdata=%h expected 1 66 0 a5", a_ack, a_rdata, b_ack, b_rdata);
            fails++;
        end
        tick();
        checks++;
        if ({a_ack, busy, bank_mem[15]} !== {1'b0, 1'b0, 8'h00}) begin
            $display("FAIL drop_after: got ack=%b busy=%b reg0f=%h expected 0 0 00", a_ack, busy, bank_mem[15]);
            fails++;
        end
    endtask

    task automatic drive_port(input bit p, input int n);
        txn_t t;
        int   gap, wc;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                set_req(p, 1'b0);
                repeat (gap) tick();
            end
            t.we    = 1'($urandom_range(0, 1));
            t.addr  = 8'($urandom_range(0, 19));
            t.wdata = 8'($urandom);
            if (p) begin b_we = t.we; b_addr = t.addr; b_wdata = t.wdata; b_req = 1'b1; qb.push_back(t); end
            else   begin a_we = t.we; a_addr = t.addr; a_wdata = t.wdata; a_req = 1'b1; qa.push_back(t); end
            wc = 0;
            do begin
                tick();
                wc++;
            end while (((p ? b_ack : a_ack) !== 1'b1) && wc < 20);
            checks++;
            if ((p ? b_ack : a_ack) !== 1'b1) begin
                $display("FAIL rand_ack_timeout: port=%0d got no ack expected ack within 20 cycles", p);
                fails++;
                break;
            end
        end
        set_req(p, 1'b0);
        if (p) done_b = 1'b1;
        else   done_a = 1'b1;
    endtask

    task automatic run_monitor();
        int   cyc = 0;
        txn_t t;
        bit   oor, ack;
        logic [7:0] rd;
        logic       er;
        while (!(done_a && done_b) && cyc < 3000) begin
            tick();
            cyc++;
            if (reg_we === 1'b1) we_seen++;
            for (int p = 0; p < 2; p++) begin
                ack = (p == 1) ? (b_ack === 1'b1) : (a_ack === 1'b1);
                if (ack) begin
                    rd = (p == 1) ? b_rdata : a_rdata;
                    er = (p == 1) ? b_err : a_err;
                    checks++;
                    if ((p == 1 ? qb.size() : qa.size()) == 0 || (a_ack === 1'b1 && b_ack === 1'b1)) begin
                        $display("FAIL rand_spurious_ack: port=%0d got ack with a_ack=%b b_ack=%b expected one pending txn", p, a_ack, b_ack);
                        fails++;
                    end else begin
                        t = (p == 1) ? qb.pop_front() : qa.pop_front();
                        oor = RC && (t.addr >= 8'(NREGS));
                        if (t.we) begin
                            if (!oor) begin
                                shadow[t.addr] = t.wdata;
                                we_expected++;
                            end
                        end else begin
                            exp_rd[p] = oor ? 8'h00 : shadow[t.addr];
                        end
                        if (rd !== exp_rd[p] || er !== oor) begin
                            $display("FAIL rand_resp: port=%0d we=%b addr=%h got rdata=%h err=%b expected %h %b",
                                     p, t.we, t.addr, rd, er, exp_rd[p], oor);
                            fails++;
                        end
                    end
                end
            end
        end
        checks++;
        if (!(done_a && done_b)) begin
            $display("FAIL rand_monitor_timeout: got unfinished drivers expected completion in 3000 cycles");
            fails++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = bank_mem[i];
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        done_a = 1'b0;
        done_b = 1'b0;
        we_seen = 0;
        we_expected = 0;
        qa.delete();
        qb.delete();
        fork
            drive_port(1'b0, 40);
            drive_port(1'b1, 40);
            run_monitor();
        join
        repeat (4) tick();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            $display("FAIL rand_lost_ack: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
            fails++;
        end
        checks++;
        if (we_seen != we_expected) begin
            $display("FAIL rand_we_count: got %0d expected %0d", we_seen, we_expected);
            fails++;
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_abort();
        test_range();
        test_drop_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
